phase_freq_est: RTL and testbench
=================================

Name: phase_freq_est

Overview:
- Sits directly downstream of the atan2 stage and consumes its wrapped Q1.15 angle stream (units of pi rad).
- Unwraps the phase into a wide accumulator.
- Produces a block-averaged instantaneous frequency (phase step per sample) once every 2^AVG_LOG2 phase differences.
- Used for carrier/Doppler tracking after the I/Q-to-angle conversion.

Parameters:
- TURN_WIDTH, 16: extra integer bits of the unwrapped phase accumulator. Accumulator is Q(TURN_WIDTH+1).15 in pi rad.
- AVG_LOG2, 4: log2 of the number of phase differences averaged per frequency output. Legal range 1..8.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- sync  in  1  restart request: discard history and return to EMPTY.
- sink  in  16  wrapped phase, Q1.15, pi rad. The upstream atan2 output.
- sink_valid  in  1  sink qualifier. Delayed externally to match the atan2 latency.
- source_phase  out  TURN_WIDTH+16  unwrapped phase, Q(TURN_WIDTH+1).15, pi rad.
- source_phase_valid  out  1  one-cycle pulse per accepted sample.
- source_freq  out  16  mean phase step, Q1.15, pi rad/sample.
- source_freq_valid  out  1  one-cycle pulse per completed averaging block.

Behaviour:
- Reset, synchronous:
  - state=EMPTY; prev, acc, sum, cnt = 0.
  - All outputs 0, both valids 0.
- Idle cycles (sink_valid=0): no state change; valids are 0 the next cycle; data outputs hold their last value.
- State EMPTY, sink_valid=1:
  - prev <= sink.
  - acc <= sign-extend(sink).
  - sum, cnt <= 0.
  - source_phase <= sign-extend(sink); source_phase_valid <= 1; no freq output.
  - Next state RUN.
- State RUN, sink_valid=1:
  - d = sink - prev, computed modulo 2^16 and interpreted signed. This is the wrap-free step in [-1, 1) pi; a step of exactly ±pi maps to -1.0 (0x8000).
  - prev <= sink.
  - acc <= acc + sign-extend(d), modulo 2^(TURN_WIDTH+16). Silent wrap, no saturation.
  - source_phase <= the new acc; source_phase_valid <= 1.
  - sum (16+AVG_LOG2 bits, signed) accumulates d; cnt increments.
  - When cnt == 2^AVG_LOG2-1 with this sample:
    - source_freq <= (sum+d) >>> AVG_LOG2 (arithmetic shift, floor rounding).
    - source_freq_valid <= 1, in the same cycle as that sample's source_phase_valid.
    - sum <= 0; cnt <= 0.
- First freq output follows the (2^AVG_LOG2 + 1)-th accepted sample after EMPTY, because the first sample only seeds prev.
- Latency: 1 clk from sink_valid to both output valids. Full throughput: one sample per clk, back-to-back.
- sync=1 without sink_valid:
  - Next state EMPTY; sum, cnt cleared; no output pulse.
  - source_phase and source_freq hold their values.
- sync=1 together with sink_valid=1: the sample is handled as the EMPTY-state first sample, i.e. it re-seeds acc with sign-extend(sink).
- sync in EMPTY: no effect.
- reset has priority over sync and sink_valid. Reset mid-block discards the partial sum; no freq pulse is emitted.
- Sum width 16+AVG_LOG2 cannot overflow, since |d| ≤ 2^15 per step.

Decomposition:
- Shared package pr3_pkg:
  - typedef enum {EMPTY, RUN} pfe_state_t.
  - localparam Q15_ONE = 16'h8000 (pi), used by benches for angle constants.
- No sub-module is needed; a single always_ff block plus combinational d.
- The averaging block may later be split out as block_avg, but it is in-line for now.

Test Plan (AVG_LOG2=2, TURN_WIDTH=16 unless noted):
1. Reset, then 5 valid samples 0x0000, 0x0400, 0x0800, 0x0C00, 0x1000 -> source_phase 0x0, 0x400, 0x800, 0xC00, 0x1000. One source_freq_valid, with the 5th phase pulse, source_freq=0x0400.
2. Wrap crossing: samples 0x7000, 0x9000 -> d=+0x2000; source_phase=0x0000_9000 (positive, not 0xFFFF_9000). Reverse order 0x9000, 0x7000 -> source_phase=0xFFFF_7000.
3. Negative rate: samples 0x0000 then four steps of -0x0100 (0xFF00, 0xFE00, 0xFD00, 0xFC00) -> source_freq=0xFF00. Mixed steps +1, +1, +1, -2 LSB -> sum=+1, source_freq=0x0000 (floor).
4. sync after 3 samples of a block, then 5 samples -> no freq pulse from the aborted block. Phase re-seeds at the first new sample; freq appears after the 5th new sample. Repeat with sync coincident with sink_valid: that sample is the seed.
5. Gapped valid (1 valid every 3 clk) with the scenario-1 data -> identical outputs. Pulses are 1 clk wide and occur 1 clk after each valid.
6. Accumulator wrap: TURN_WIDTH=1, constant step 0x4000 for 20 samples -> source_phase wraps modulo 2^17 with no glitch in source_freq (0x4000). Then reset mid-block -> all outputs 0 and no freq pulse.

Source files
------------

// File: rtl/pr3_pkg.sv
// Shared definitions for the phase/frequency estimation slice.
//   pfe_state_t : unwrapper state (EMPTY = no phase history, RUN = prev valid)
//   Q15_ONE     : +/-pi in the Q1.15 angle format (pi rad units)
package pr3_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } pfe_state_t;

  localparam logic [15:0] Q15_ONE = 16'h8000;

endpackage : pr3_pkg

// File: rtl/phase_freq_est.sv
// Phase unwrapper and block-averaged frequency estimator.
// Consumes the wrapped Q1.15 angle stream from the atan2 stage, unwraps it
// into a wide accumulator and emits the mean phase step once per
// 2^AVG_LOG2 phase differences.
//
// Ports:
//   clk                 clock
//   reset               synchronous, active-high reset
//   sync                restart request: drop history, back to EMPTY
//   sink[15:0]          wrapped phase, Q1.15, pi rad
//   sink_valid          sink qualifier
//   source_phase        unwrapped phase, Q(TURN_WIDTH+1).15, pi rad
//   source_phase_valid  one-cycle pulse per accepted sample
//   source_freq[15:0]   mean phase step, Q1.15, pi rad/sample
//   source_freq_valid   one-cycle pulse per completed averaging block
module phase_freq_est
  import pr3_pkg::*;
#(
  parameter int TURN_WIDTH = 16,
  parameter int AVG_LOG2   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sync,
  input  logic [15:0]              sink,
  input  logic                     sink_valid,
  output logic [TURN_WIDTH+15:0]   source_phase,
  output logic                     source_phase_valid,
  output logic [15:0]              source_freq,
  output logic                     source_freq_valid
);

  localparam int PHASE_W = TURN_WIDTH + 16;
  localparam int SUM_W   = 16 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};
  localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(1);

  pfe_state_t           state_r;
  pfe_state_t           state_next_s;
  logic [15:0]          prev_r;
  logic [PHASE_W-1:0]   acc_r;
  logic [SUM_W-1:0]     sum_r;
  logic [AVG_LOG2-1:0]  cnt_r;

  logic [15:0]          d_s;
  logic [PHASE_W-1:0]   d_ext_s;
  logic [PHASE_W-1:0]   sink_ext_s;
  logic [PHASE_W-1:0]   acc_next_s;
  logic [SUM_W-1:0]     sum_next_s;
  logic [15:0]          avg_s;
  logic                 seed_s;
  logic                 step_s;
  logic                 last_s;

  // Phase step, extensions, running sum and sample classification.
  always_comb begin
    // Modulo-2^16 difference: the shortest signed step, +/-pi lands on 0x8000.
    d_s        = sink - prev_r;
    d_ext_s    = {{TURN_WIDTH{d_s[15]}}, d_s};
    sink_ext_s = {{TURN_WIDTH{sink[15]}}, sink};
    acc_next_s = acc_r + d_ext_s;
    sum_next_s = sum_r + {{AVG_LOG2{d_s[15]}}, d_s};
    // Arithmetic shift right by AVG_LOG2 then keep 16 bits is exactly this
    // slice; dropping the low bits gives floor rounding.
    avg_s      = sum_next_s[SUM_W-1:AVG_LOG2];
    // A sync coincident with a sample turns that sample into a new seed.
    seed_s     = sink_valid & ((state_r == EMPTY) | sync);
    step_s     = sink_valid & (state_r == RUN) & ~sync;
    last_s     = (cnt_r == CNT_LAST);
  end

  // Next-state logic: any accepted sample leaves us in RUN, bare sync empties.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (sink_valid) begin
          state_next_s = RUN;
        end else begin
          state_next_s = EMPTY;
        end
      end
      RUN: begin
        if (sink_valid) begin
          state_next_s = RUN;
        end else if (sync) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r             <= 16'h0000;
      acc_r              <= '0;
      sum_r              <= '0;
      cnt_r              <= '0;
      source_phase       <= '0;
      source_phase_valid <= 1'b0;
      source_freq        <= 16'h0000;
      source_freq_valid  <= 1'b0;
    end else begin
      source_phase_valid <= 1'b0;
      source_freq_valid  <= 1'b0;
      if (seed_s) begin
        prev_r             <= sink;
        acc_r              <= sink_ext_s;
        sum_r              <= '0;
        cnt_r              <= '0;
        source_phase       <= sink_ext_s;
        source_phase_valid <= 1'b1;
      end else if (step_s) begin
        prev_r             <= sink;
        acc_r              <= acc_next_s;
        source_phase       <= acc_next_s;
        source_phase_valid <= 1'b1;
        if (last_s) begin
          source_freq       <= avg_s;
          source_freq_valid <= 1'b1;
          sum_r             <= '0;
          cnt_r             <= '0;
        end else begin
          sum_r <= sum_next_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else if (sync) begin
        // Abort the partial block; data outputs keep their last values.
        sum_r <= '0;
        cnt_r <= '0;
      end
    end
  end

endmodule : phase_freq_est

// File: tb/tb_phase_freq_est.sv
module tb_phase_freq_est;
  import pr3_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: TURN_WIDTH=16, AVG_LOG2=2
  logic        reset_a, sync_a, sink_valid_a;
  logic [15:0] sink_a;
  logic [31:0] phase_a;
  logic        pv_a, fv_a;
  logic [15:0] freq_a;

  // DUT B: TURN_WIDTH=1, AVG_LOG2=2 (accumulator wrap)
  logic        reset_b, sync_b, sink_valid_b;
  logic [15:0] sink_b;
  logic [16:0] phase_b;
  logic        pv_b, fv_b;
  logic [15:0] freq_b;

  phase_freq_est #(.TURN_WIDTH(16), .AVG_LOG2(2)) dut_a (
    .clk(clk), .reset(reset_a), .sync(sync_a), .sink(sink_a),
    .sink_valid(sink_valid_a), .source_phase(phase_a),
    .source_phase_valid(pv_a), .source_freq(freq_a),
    .source_freq_valid(fv_a)
  );

  phase_freq_est #(.TURN_WIDTH(1), .AVG_LOG2(2)) dut_b (
    .clk(clk), .reset(reset_b), .sync(sync_b), .sink(sink_b),
    .sink_valid(sink_valid_b), .source_phase(phase_b),
    .source_phase_valid(pv_b), .source_freq(freq_b),
    .source_freq_valid(fv_b)
  );

  typedef struct {
    logic        rst;
    logic        syn;
    logic        vld;
    logic [15:0] sink;
    logic        pv;
    logic [31:0] phase;
    logic        fv;
    logic [15:0] freq;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, input logic syn, input logic vld,
                     input logic [15:0] sink, input logic pv,
                     input logic [31:0] phase, input logic fv,
                     input logic [15:0] freq);
    vec_t v;
    v.rst = rst; v.syn = syn; v.vld = vld; v.sink = sink;
    v.pv = pv; v.phase = phase; v.fv = fv; v.freq = freq;
    tbl.push_back(v);
  endtask

  task automatic rst_v();
    add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000);
  endtask

  task automatic samp(input logic [15:0] s, input logic [31:0] ph,
                      input logic fv, input logic [15:0] fr);
    add(1'b0, 1'b0, 1'b1, s, 1'b1, ph, fv, fr);
  endtask

  task automatic idle(input logic [31:0] ph, input logic [15:0] fr);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, ph, 1'b0, fr);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    reset_a = 1'b1; sync_a = 1'b0; sink_valid_a = 1'b0; sink_a = 16'h0000;
    reset_b = 1'b1; sync_b = 1'b0; sink_valid_b = 1'b0; sink_b = 16'h0000;

    // 1: linear ramp, step 0x400
    rst_v();
    samp(16'h0000, 32'h0000_0000, 1'b0, 16'h0000);
    samp(16'h0400, 32'h0000_0400, 1'b0, 16'h0000);
    samp(16'h0800, 32'h0000_0800, 1'b0, 16'h0000);
    samp(16'h0C00, 32'h0000_0C00, 1'b0, 16'h0000);
    samp(16'h1000, 32'h0000_1000, 1'b1, 16'h0400);
    idle(32'h0000_1000, 16'h0400);
    // 2: wrap crossing both directions (sync+valid reseeds)
    add(1'b0, 1'b1, 1'b1, 16'h7000, 1'b1, 32'h0000_7000, 1'b0, 16'h0400);
    samp(16'h9000, 32'h0000_9000, 1'b0, 16'h0400);
    add(1'b0, 1'b1, 1'b1, 16'h9000, 1'b1, 32'hFFFF_9000, 1'b0, 16'h0400);
    samp(16'h7000, 32'hFFFF_7000, 1'b0, 16'h0400);
    // 3: negative rate, floor rounding, +/-pi step
    rst_v();
    samp(16'h0000, 32'h0000_0000, 1'b0, 16'h0000);
    samp(16'hFF00, 32'hFFFF_FF00, 1'b0, 16'h0000);
    samp(16'hFE00, 32'hFFFF_FE00, 1'b0, 16'h0000);
    samp(16'hFD00, 32'hFFFF_FD00, 1'b0, 16'h0000);
    samp(16'hFC00, 32'hFFFF_FC00, 1'b1, 16'hFF00);
    samp(16'hFC01, 32'hFFFF_FC01, 1'b0, 16'hFF00);
    samp(16'hFC02, 32'hFFFF_FC02, 1'b0, 16'hFF00);
    samp(16'hFC03, 32'hFFFF_FC03, 1'b0, 16'hFF00);
    samp(16'hFC01, 32'hFFFF_FC01, 1'b1, 16'h0000);
    samp(16'hFC00, 32'hFFFF_FC00, 1'b0, 16'h0000);
    samp(16'hFBFF, 32'hFFFF_FBFF, 1'b0, 16'h0000);
    samp(16'hFBFE, 32'hFFFF_FBFE, 1'b0, 16'h0000);
    samp(16'hFC00, 32'hFFFF_FC00, 1'b1, 16'hFFFF);
    samp(16'hFC00 + Q15_ONE, 32'hFFFF_7C00, 1'b0, 16'hFFFF);
    samp(16'h7C00, 32'hFFFF_7C00, 1'b0, 16'hFFFF);
    samp(16'h7C00, 32'hFFFF_7C00, 1'b0, 16'hFFFF);
    samp(16'h7C00, 32'hFFFF_7C00, 1'b1, 16'hE000);
    // 4a: sync alone aborts a partial block
    rst_v();
    add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 16'h0000);
    samp(16'h0000, 32'h0000_0000, 1'b0, 16'h0000);
    samp(16'h0100, 32'h0000_0100, 1'b0, 16'h0000);
    samp(16'h0200, 32'h0000_0200, 1'b0, 16'h0000);
    samp(16'h0300, 32'h0000_0300, 1'b0, 16'h0000);
    add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 32'h0000_0300, 1'b0, 16'h0000);
    samp(16'h1000, 32'h0000_1000, 1'b0, 16'h0000);
    samp(16'h1200, 32'h0000_1200, 1'b0, 16'h0000);
    samp(16'h1400, 32'h0000_1400, 1'b0, 16'h0000);
    samp(16'h1600, 32'h0000_1600, 1'b0, 16'h0000);
    samp(16'h1800, 32'h0000_1800, 1'b1, 16'h0200);
    // 4b: sync coincident with a sample makes it the seed
    samp(16'h2000, 32'h0000_2000, 1'b0, 16'h0200);
    samp(16'h2100, 32'h0000_2100, 1'b0, 16'h0200);
    samp(16'h2200, 32'h0000_2200, 1'b0, 16'h0200);
    add(1'b0, 1'b1, 1'b1, 16'h5000, 1'b1, 32'h0000_5000, 1'b0, 16'h0200);
    samp(16'h5040, 32'h0000_5040, 1'b0, 16'h0200);
    samp(16'h5080, 32'h0000_5080, 1'b0, 16'h0200);
    samp(16'h50C0, 32'h0000_50C0, 1'b0, 16'h0200);
    samp(16'h5100, 32'h0000_5100, 1'b1, 16'h0040);
    // 5: gapped valid, one sample every 3 clocks
    rst_v();
    for (int i = 0; i < 5; i++) begin
      logic [15:0] s;
      logic [15:0] f;
      s = 16'(i * 32'h400);
      f = (i == 4) ? 16'h0400 : 16'h0000;
      samp(s, {16'h0000, s}, (i == 4), f);
      idle({16'h0000, s}, f);
      idle({16'h0000, s}, f);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset_a      = tbl[i].rst;
      sync_a       = tbl[i].syn;
      sink_valid_a = tbl[i].vld;
      sink_a       = tbl[i].sink;
      @(posedge clk);
      #1;
      n_vec++;
      check($sformatf("v%0d phase_valid", i), {31'h0, pv_a}, {31'h0, tbl[i].pv});
      check($sformatf("v%0d phase", i), phase_a, tbl[i].phase);
      check($sformatf("v%0d freq_valid", i), {31'h0, fv_a}, {31'h0, tbl[i].fv});
      check($sformatf("v%0d freq", i), {16'h0, freq_a}, {16'h0, tbl[i].freq});
    end
    @(negedge clk);
    sink_valid_a = 1'b0; sync_a = 1'b0; reset_a = 1'b0;

    // 6: accumulator wrap on TURN_WIDTH=1, then reset mid-block
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    check("w reset phase", {15'h0, phase_b}, 32'h0);
    check("w reset freq", {16'h0, freq_b}, 32'h0);
    for (int k = 0; k < 20; k++) begin
      logic [31:0] exp_ph;
      logic        exp_fv;
      logic [15:0] exp_fr;
      @(negedge clk);
      reset_b      = 1'b0;
      sink_valid_b = 1'b1;
      sink_b       = 16'(k * 32'h4000);
      @(posedge clk);
      #1;
      exp_ph = (k * 32'h4000) & 32'h0001_FFFF;
      exp_fv = (k > 0) && ((k % 4) == 0);
      exp_fr = (k >= 4) ? 16'h4000 : 16'h0000;
      n_vec++;
      check($sformatf("w%0d phase", k), {15'h0, phase_b}, exp_ph);
      check($sformatf("w%0d phase_valid", k), {31'h0, pv_b}, 32'h1);
      check($sformatf("w%0d freq_valid", k), {31'h0, fv_b}, {31'h0, exp_fv});
      check($sformatf("w%0d freq", k), {16'h0, freq_b}, {16'h0, exp_fr});
    end
    // This sample would close a block, but reset wins.
    @(negedge clk);
    reset_b = 1'b1;
    sink_b  = 16'h0000;
    @(posedge clk);
    #1;
    n_vec++;
    check("w midreset phase", {15'h0, phase_b}, 32'h0);
    check("w midreset phase_valid", {31'h0, pv_b}, 32'h0);
    check("w midreset freq_valid", {31'h0, fv_b}, 32'h0);
    check("w midreset freq", {16'h0, freq_b}, 32'h0);
    @(negedge clk);
    reset_b = 1'b0;
    sink_valid_b = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    check("w post phase_valid", {31'h0, pv_b}, 32'h0);
    check("w post freq_valid", {31'h0, fv_b}, 32'h0);
    check("w post freq", {16'h0, freq_b}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_phase_freq_est
